// File: rtl/cbuf_rr_arbiter.sv
// Packet-aware round-robin arbiter feeding the circular buffer write port.
// One winner per packet; beats pass through a single registered output stage.
module cbuf_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 8,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [NUM_REQ-1:0]        valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] data_i,
  input  logic [NUM_REQ-1:0]        last_i,
  output logic [NUM_REQ-1:0]        ready_o,
  output logic                      valid_o,
  output logic [DATA_W-1:0]         data_o,
  output logic                      last_o,
  output logic [ID_W-1:0]           id_o,
  input  logic                      ready_i
);

  // state    | meaning
  // S_IDLE   | no packet in progress; round-robin search from rr_ptr
  // S_LOCKED | mid-packet; only lock_id may transfer until its last beat
  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   lock_id_q, lock_id_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic              load;
  logic              found;
  logic              accept;
  logic [ID_W-1:0]   sel;
  logic [ID_W-1:0]   sel_next;
  logic              sel_last;

  assign load = !valid_q || ready_i;

  always_comb begin
    int idx;
    logic [ID_W-1:0] cand;
    idx   = 0;
    cand  = '0;
    sel   = rr_ptr_q;
    found = 1'b0;
    if (state_q == S_LOCKED) begin
      sel   = lock_id_q;
      found = valid_i[lock_id_q];
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = int'(rr_ptr_q) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        cand = ID_W'(idx);
        if (!found && valid_i[cand]) begin
          found = 1'b1;
          sel   = cand;
        end
      end
    end
  end

  // Gating with arst_n keeps requesters from seeing a handshake during reset.
  assign accept   = load && found && arst_n;
  assign ready_o  = accept ? (NUM_REQ'(1) << sel) : '0;
  assign sel_last = last_i[sel];
  assign sel_next = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + ID_W'(1);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    if (accept) begin
      if (sel_last) begin
        state_d  = S_IDLE;
        rr_ptr_d = sel_next;
      end else begin
        state_d   = S_LOCKED;
        lock_id_d = sel;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    id_d    = id_q;
    if (load) valid_d = accept;
    if (accept) begin
      data_d = data_i[int'(sel)*DATA_W +: DATA_W];
      last_d = sel_last;
      id_d   = sel;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      last_q    <= 1'b0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      last_q    <= last_d;
      id_q      <= id_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign id_o    = id_q;

endmodule

// File: tb/tb_cbuf_rr_arbiter.sv
// Bench for cbuf_rr_arbiter: directed vector table, corner-case sequences and
// a randomized run against a packet-level reference model.
module tb_cbuf_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          arst_n;
  logic [N-1:0]  valid_i;
  logic [N*DW-1:0] data_i;
  logic [N-1:0]  last_i;
  logic [N-1:0]  ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          last_o;
  logic [1:0]    id_o;
  logic          ready_i;

  int checks = 0;
  int errors = 0;

  // reference model: owner of packet in progress (-1 = none) and output register
  int          m_owner, m_ptr;
  logic        m_vo, m_lo;
  logic [DW-1:0] m_do;
  int          m_io;

  cbuf_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
    .clk(clk), .arst_n(arst_n), .valid_i(valid_i), .data_i(data_i),
    .last_i(last_i), .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
    .last_o(last_o), .id_o(id_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] v;
    logic [N-1:0] l;
    logic         rdy;
    logic [N-1:0] er;
    logic         ev;
    logic [1:0]   eid;
    logic         el;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mreset();
    m_owner = -1; m_ptr = 0; m_vo = 0; m_do = '0; m_lo = 0; m_io = 0;
  endtask

  function automatic int model_sel();
    int s;
    s = -1;
    if (arst_n && (!m_vo || ready_i)) begin
      if (m_owner >= 0) begin
        if (valid_i[m_owner]) s = m_owner;
      end else begin
        for (int i = 0; i < N; i++)
          if (s < 0 && valid_i[(m_ptr + i) % N]) s = (m_ptr + i) % N;
      end
    end
    return s;
  endfunction

  task automatic check_model();
    int s;
    logic [N-1:0] er;
    if (!arst_n) mreset();
    s  = model_sel();
    er = '0;
    if (s >= 0) er[s] = 1'b1;
    chk("m_ready", 32'(ready_o), 32'(er));
    chk("m_valid", 32'(valid_o), 32'(m_vo));
    chk("m_data",  32'(data_o),  32'(m_do));
    chk("m_last",  32'(last_o),  32'(m_lo));
    chk("m_id",    32'(id_o),    32'(m_io));
  endtask

  task automatic at_neg();
    @(negedge clk);
    check_model();
  endtask

  task automatic tick();
    int s;
    @(posedge clk);
    if (!arst_n) mreset();
    else begin
      s = model_sel();
      if (s >= 0) begin
        m_vo = 1; m_do = data_i[s*DW +: DW]; m_lo = last_i[s]; m_io = s;
        if (last_i[s]) begin m_owner = -1; m_ptr = (s + 1) % N; end
        else m_owner = s;
      end else if (!m_vo || ready_i) m_vo = 0;
    end
    #1;
  endtask

  task automatic cyc();
    at_neg();
    tick();
  endtask

  task automatic do_reset();
    arst_n = 0; valid_i = '0; last_i = '0; ready_i = 1;
    data_i = {8'h13, 8'h12, 8'h11, 8'h10};
    cyc(); cyc();
    arst_n = 1;
  endtask

  initial begin
    mreset();
    arst_n = 0; ready_i = 1; valid_i = '1; last_i = '1;
    data_i = {8'h13, 8'h12, 8'h11, 8'h10};

    //            valid    last     rdy  exp_ready exp_vo eid   elast
    tbl[0]  = '{4'b1111, 4'b1111, 1, 4'b0001, 0, 2'd0, 0};
    tbl[1]  = '{4'b1111, 4'b1111, 1, 4'b0010, 1, 2'd0, 1};
    tbl[2]  = '{4'b1111, 4'b1111, 1, 4'b0100, 1, 2'd1, 1};
    tbl[3]  = '{4'b1111, 4'b1111, 1, 4'b1000, 1, 2'd2, 1};
    tbl[4]  = '{4'b1111, 4'b1111, 1, 4'b0001, 1, 2'd3, 1};
    tbl[5]  = '{4'b1101, 4'b1011, 1, 4'b0100, 1, 2'd0, 1};
    tbl[6]  = '{4'b1101, 4'b1011, 1, 4'b0100, 1, 2'd2, 0};
    tbl[7]  = '{4'b1101, 4'b1111, 1, 4'b0100, 1, 2'd2, 0};
    tbl[8]  = '{4'b1101, 4'b1111, 1, 4'b1000, 1, 2'd2, 1};
    tbl[9]  = '{4'b1101, 4'b1111, 1, 4'b0001, 1, 2'd3, 1};
    tbl[10] = '{4'b0000, 4'b1111, 1, 4'b0000, 1, 2'd0, 1};
    tbl[11] = '{4'b0000, 4'b1111, 1, 4'b0000, 0, 2'd0, 1};

    // reset held with every requester valid
    for (int c = 0; c < 5; c++) begin
      at_neg();
      chk("rst_ready", 32'(ready_o), 0);
      chk("rst_valid", 32'(valid_o), 0);
      chk("rst_id",    32'(id_o),    0);
      tick();
    end
    arst_n = 1;

    // fairness and packet lock
    for (int r = 0; r < 12; r++) begin
      valid_i = tbl[r].v; last_i = tbl[r].l; ready_i = tbl[r].rdy;
      at_neg();
      chk($sformatf("tbl%0d_ready", r), 32'(ready_o), 32'(tbl[r].er));
      chk($sformatf("tbl%0d_valid", r), 32'(valid_o), 32'(tbl[r].ev));
      chk($sformatf("tbl%0d_id", r),    32'(id_o),    32'(tbl[r].eid));
      chk($sformatf("tbl%0d_last", r),  32'(last_o),  32'(tbl[r].el));
      tick();
    end

    // backpressure holds the output stage
    do_reset();
    data_i[7:0] = 8'hA5; valid_i = 4'b0001; last_i = '1;
    cyc();
    ready_i = 0; valid_i = '1;
    for (int c = 0; c < 4; c++) begin
      at_neg();
      chk("bp_valid", 32'(valid_o), 1);
      chk("bp_data",  32'(data_o),  32'h A5);
      chk("bp_ready", 32'(ready_o), 0);
      tick();
    end
    ready_i = 1;
    at_neg();
    chk("bp_resume_ready", 32'(ready_o), 32'b0010);
    tick();
    at_neg();
    chk("bp_next_valid", 32'(valid_o), 1);
    chk("bp_next_id",    32'(id_o),    1);
    chk("bp_next_data",  32'(data_o),  32'h11);
    tick();

    // locked bubble: requester 1 stalls mid-packet, requester 0 must wait
    do_reset();
    valid_i = 4'b0010; last_i = 4'b0000; cyc();
    valid_i = 4'b0011;
    at_neg(); chk("bub_ready1", 32'(ready_o), 32'b0010); tick();
    valid_i = 4'b0001;
    at_neg(); chk("bub_gap1", 32'(ready_o), 0); tick();
    at_neg(); chk("bub_gap2", 32'(ready_o), 0); chk("bub_vo0", 32'(valid_o), 0); tick();
    valid_i = 4'b0011; last_i = 4'b0010;
    at_neg(); chk("bub_last1", 32'(ready_o), 32'b0010); tick();
    valid_i = 4'b0001; last_i = 4'b0001;
    at_neg(); chk("bub_ready0", 32'(ready_o), 32'b0001);
    chk("bub_id1", 32'(id_o), 1); chk("bub_lasto", 32'(last_o), 1); tick();
    valid_i = 4'b0000;
    at_neg(); chk("bub_id0", 32'(id_o), 0); tick();

    // reset in the middle of a packet from requester 3
    do_reset();
    valid_i = 4'b1000; last_i = 4'b0000; cyc();
    valid_i = 4'b1001; arst_n = 0;
    at_neg(); chk("mrst_ready", 32'(ready_o), 0); chk("mrst_valid", 32'(valid_o), 0); tick();
    cyc();
    arst_n = 1;
    at_neg(); chk("mrst_win0", 32'(ready_o), 32'b0001); tick();
    at_neg(); chk("mrst_id", 32'(id_o), 0); chk("mrst_vo", 32'(valid_o), 1); tick();

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        valid_i[k] = ($urandom_range(0, 9) < 6);
        last_i[k]  = ($urandom_range(0, 9) < 4);
      end
      data_i  = {$urandom(), $urandom()} ;
      ready_i = ($urandom_range(0, 9) < 7);
      arst_n  = ($urandom_range(0, 499) != 0);
      cyc();
    end
    arst_n = 1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cbuf_rr_arbiter.md
# cbuf_rr_arbiter

Round-robin, packet-aware arbiter that shares the single valid/ready write port of the circular buffer between `NUM_REQ` requesters. It selects one requester per packet and holds the grant until that requester's last beat is transferred. It forwards beats through one registered output stage. The block sits directly upstream of the circular buffer: its output handshake (`valid_o`/`ready_i`) connects to the buffer's input handshake.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters; legal range ≥ 2.
- `DATA_W`, 8, beat payload width in bits.
- `ID_W`, `$clog2(NUM_REQ)`, width of the source-id output; derived, not overridden.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `arst_n`  in  1  asynchronous, active-low reset.
- `valid_i`  in  NUM_REQ  per-requester beat valid.
- `data_i`  in  NUM_REQ*DATA_W  per-requester payload; requester k occupies bits [k*DATA_W +: DATA_W].
- `last_i`  in  NUM_REQ  per-requester end-of-packet marker.
- `ready_o`  out  NUM_REQ  per-requester ready; combinational.
- `valid_o`  out  1  registered beat valid toward the buffer.
- `data_o`  out  DATA_W  registered payload.
- `last_o`  out  1  registered end-of-packet marker.
- `id_o`  out  ID_W  index of the requester that sourced the beat.
- `ready_i`  in  1  buffer ready.

## Operation
- Output register is free when `load = !valid_o || ready_i`.
- State machine has two states, IDLE and LOCKED. Reset state is IDLE.
- IDLE:
  - Winner is the first k with `valid_i[k]=1`, searching from `rr_ptr` upward with wrap-around modulo NUM_REQ.
  - If a winner exists and `load=1`, the beat is accepted.
  - If the accepted beat has `last_i=1`, the FSM stays in IDLE and `rr_ptr` becomes (winner+1) mod NUM_REQ.
  - If the accepted beat has `last_i=0`, the FSM goes to LOCKED, `lock_id` becomes the winner, and `rr_ptr` is unchanged.
- LOCKED:
  - Only `lock_id` is eligible. Other requesters see `ready_o=0` even if `lock_id` is idle (bubbles allowed).
  - An accepted beat from `lock_id` with `last_i=1` sets `rr_ptr` to (lock_id+1) mod NUM_REQ and returns the FSM to IDLE.
- `ready_o[k] = load && (k == selected requester) && (selected requester is valid)`. At most one bit of `ready_o` is set per cycle.
- `ready_o` never depends on a requester's own `valid_i` beyond the selection rule; `valid_i` may depend on `ready_o` only if the requester does so without a combinational loop.
- Beat accepted when `valid_i[k] && ready_o[k]`. On acceptance, `data_o`, `last_o`, `id_o` and `valid_o=1` load on the next edge.
- If `load=1` and no beat is accepted, `valid_o` goes to 0; `data_o`/`last_o`/`id_o` hold their values.
- While `valid_o && !ready_i`, all output fields hold stable and every `ready_o` is 0.
- Reset values: `valid_o=0`, `data_o=0`, `last_o=0`, `id_o=0`, `rr_ptr=0`, `lock_id=0`, state IDLE. While `arst_n=0`, `ready_o=0`.
- Reset asserted mid-packet clears immediately, including the lock; any partial packet is abandoned, no recovery.

## Timing
- Latency is 1 cycle from input acceptance to `valid_o`.
- Throughput is 1 beat/cycle when `ready_i=1` continuously, including back-to-back packets from different requesters.
- `rr_ptr` update and FSM transition take effect on the edge of the accepting cycle; the next cycle's arbitration uses the new values.
- Output acceptance and input acceptance in the same cycle is legal (pipeline pass-through); no bubble is inserted.
- Single-beat packet (`last_i=1` on the first beat) never enters LOCKED.
- `ready_i` deasserted while LOCKED: lock is kept; arbitration resumes with the same owner.

## Test plan
- Reset: hold `arst_n=0` 5 cycles with all `valid_i=1` -> `ready_o=0`, `valid_o=0`, `id_o=0`. Release -> first grant goes to requester 0, and `valid_o=1` one cycle later.
- Fairness: NUM_REQ=4, all requesters always valid, single-beat packets, `ready_i=1` -> `id_o` sequence is 0,1,2,3,0,1… with one beat per cycle and no gaps.
- Packet lock: requester 2 sends a 3-beat packet (last on beat 3); requesters 0 and 3 are valid throughout -> `id_o`=2,2,2, then 3, then 0. `last_o=1` only on the third beat.
- Backpressure: `ready_i=0` for 4 cycles while `valid_o=1`, `data_o=8'hA5` -> outputs stable, all `ready_o=0`. On `ready_i=1`, the next beat appears the following cycle.
- Locked bubble: requester 1 mid-packet drops `valid_i` for 2 cycles while requester 0 is valid -> `ready_o[0]` stays 0, `valid_o` drops to 0, and requester 1's packet completes before requester 0 is granted.
- Reset mid-packet: assert `arst_n=0` after beat 1 of a 4-beat packet from requester 3 -> FSM returns to IDLE. After release, requester 0 (valid) wins first.
